// File: rtl/elastic_pipe_reg_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | elastic_pipe_reg_if                                                   |
// | Upstream/downstream ready-valid bundle for elastic_pipe_reg.          |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface elastic_pipe_reg_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface
`default_nettype wire

// File: rtl/elastic_pipe_reg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | elastic_pipe_reg                                                      |
// | DEPTH-stage elastic register chain with bubble collapse and flush.    |
// | Optional macro ELASTIC_PIPE_REG_DATA_CLEAR_EN clears data to RESET_VAL|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module elastic_pipe_reg #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
`ifdef ELASTIC_PIPE_REG_DATA_CLEAR_EN
   ,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
`endif
) (
   input  wire logic                       clk,
   input  wire logic                       rst_n,
   input  wire logic                       flush,
   elastic_pipe_reg_if.slave               pipe,
   output logic [$clog2(DEPTH+1)-1:0]      occupancy
);
   localparam int OCC_W = $clog2(DEPTH+1);

   logic [DEPTH-1:0] r_valid;
   logic [WIDTH-1:0] r_data [DEPTH];
   logic [DEPTH-1:0] w_adv;
   logic [DEPTH-1:0] w_load;
   logic [WIDTH-1:0] w_src [DEPTH];
   logic             w_fullAhead;
   logic             w_inReady;
   logic             w_accept;
   logic [OCC_W-1:0] w_occ;

   // A stage advances when any stage ahead of it has a hole, or the whole
   // tail is full and the consumer is taking the head entry.
   always_comb begin
      w_fullAhead = 1'b1;
      w_adv       = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         w_adv[k]    = r_valid[k] & (~w_fullAhead | pipe.out_ready);
         w_fullAhead = w_fullAhead & r_valid[k];
      end
   end

   assign w_inReady = ~flush & (~r_valid[0] | w_adv[0]);
   assign w_accept  = pipe.in_valid & w_inReady;

   always_comb begin
      w_load    = '0;
      w_load[0] = w_accept;
      w_src[0]  = pipe.in_data;
      for (int k = 1; k < DEPTH; k++) begin
         w_load[k] = w_adv[k-1];
         w_src[k]  = r_data[k-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
      end else if (flush) begin
         r_valid <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            if (w_load[k]) begin
               r_valid[k] <= 1'b1;
            end else if (w_adv[k]) begin
               r_valid[k] <= 1'b0;
            end
         end
      end
   end

`ifdef ELASTIC_PIPE_REG_DATA_CLEAR_EN
   // Data tracks its valid bit: any stage that empties returns to RESET_VAL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_data[k] <= RESET_VAL;
         end
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            if (flush || (w_adv[k] && !w_load[k])) begin
               r_data[k] <= RESET_VAL;
            end else if (w_load[k]) begin
               r_data[k] <= w_src[k];
            end
         end
      end
   end
`else
   always_ff @(posedge clk) begin
      for (int k = 0; k < DEPTH; k++) begin
         if (w_load[k]) begin
            r_data[k] <= w_src[k];
         end
      end
   end
`endif

   always_comb begin
      w_occ = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_occ = w_occ + OCC_W'(r_valid[k]);
      end
   end

   assign pipe.in_ready  = w_inReady;
   assign pipe.out_valid = r_valid[DEPTH-1];
   assign pipe.out_data  = r_data[DEPTH-1];
   assign occupancy      = w_occ;
endmodule
`default_nettype wire

// File: tb/tb_elastic_pipe_reg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_elastic_pipe_reg                                                   |
// | Directed vector table (DEPTH=2) plus reset and bubble sequences.      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_elastic_pipe_reg;
`ifdef ELASTIC_PIPE_REG_DATA_CLEAR_EN
   localparam bit CLR = 1'b1;
`else
   localparam bit CLR = 1'b0;
`endif
   localparam logic [7:0] STALE33 = CLR ? 8'h00 : 8'h33;
   localparam int NVEC = 15;

   typedef struct {
      logic       inValid;
      logic [7:0] inData;
      logic       outReady;
      logic       flush;
      logic       expInReady;
      logic       expOutValid;
      logic       chkData;
      logic [7:0] expOutData;
      logic [1:0] expOcc;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic       flush;
   logic       flush3;
   logic [1:0] occ;
   logic [1:0] occ3;
   int         total;
   int         bad;
   vec_t       vecs [NVEC];

   elastic_pipe_reg_if #(.WIDTH(8)) pif ();
   elastic_pipe_reg_if #(.WIDTH(8)) pif3 ();

   elastic_pipe_reg #(.WIDTH(8), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .pipe(pif.slave), .occupancy(occ)
   );

   elastic_pipe_reg #(.WIDTH(8), .DEPTH(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .flush(flush3), .pipe(pif3.slave), .occupancy(occ3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      vecs[0]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0};
      vecs[1]  = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd1};
      vecs[2]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 2'd2};
      vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h22, 2'd2};
      vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33, 2'd1};
      vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, STALE33, 2'd0};
      vecs[6]  = '{1'b1, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, STALE33, 2'd0};
      vecs[7]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, STALE33, 2'd1};
      vecs[8]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 2'd2};
      vecs[9]  = '{1'b1, 8'hA2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA0, 2'd2};
      vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA1, 2'd2};
      vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA2, 2'd1};
      vecs[12] = '{1'b1, 8'hB0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA2, 2'd1};
      vecs[13] = '{1'b1, 8'hC0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA2, 2'd2};
      vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, CLR,  8'h00, 2'd0};

      rst_n = 1'b0;
      flush = 1'b0;
      flush3 = 1'b0;
      pif.in_valid = 1'b0;
      pif.in_data = '0;
      pif.out_ready = 1'b0;
      pif3.in_valid = 1'b0;
      pif3.in_data = '0;
      pif3.out_ready = 1'b0;

      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      #1;
      check("rst.inReady", 32'(pif.in_ready), 32'd1);
      check("rst.outValid", 32'(pif.out_valid), 32'd0);
      check("rst.occ", 32'(occ), 32'd0);
      check("rst3.outValid", 32'(pif3.out_valid), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         pif.in_valid  = vecs[i].inValid;
         pif.in_data   = vecs[i].inData;
         pif.out_ready = vecs[i].outReady;
         flush         = vecs[i].flush;
         #1;
         check($sformatf("v%0d.inReady", i), 32'(pif.in_ready), 32'(vecs[i].expInReady));
         check($sformatf("v%0d.outValid", i), 32'(pif.out_valid), 32'(vecs[i].expOutValid));
         check($sformatf("v%0d.occ", i), 32'(occ), 32'(vecs[i].expOcc));
         if (vecs[i].chkData)
            check($sformatf("v%0d.outData", i), 32'(pif.out_data), 32'(vecs[i].expOutData));
      end

      // Asynchronous reset while full.
      @(negedge clk);
      pif.in_valid = 1'b1;
      pif.in_data = 8'hD1;
      pif.out_ready = 1'b0;
      @(negedge clk);
      pif.in_data = 8'hD2;
      @(negedge clk);
      pif.in_valid = 1'b0;
      #1;
      check("ar.occBefore", 32'(occ), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar.outValid", 32'(pif.out_valid), 32'd0);
      check("ar.occ", 32'(occ), 32'd0);
      check("ar.inReady", 32'(pif.in_ready), 32'd1);
      if (CLR)
         check("ar.outData", 32'(pif.out_data), 32'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // Bubble collapse on the 3-stage instance.
      pif3.in_valid = 1'b1;
      pif3.in_data = 8'h05;
      #1;
      check("bc.inReady0", 32'(pif3.in_ready), 32'd1);
      @(negedge clk);
      pif3.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("bc.occ1", 32'(occ3), 32'd1);
      check("bc.outValid", 32'(pif3.out_valid), 32'd1);
      check("bc.outData5", 32'(pif3.out_data), 32'h05);
      pif3.in_valid = 1'b1;
      pif3.in_data = 8'h06;
      #1;
      check("bc.inReady1", 32'(pif3.in_ready), 32'd1);
      @(negedge clk);
      pif3.in_valid = 1'b0;
      @(negedge clk);
      #1;
      check("bc.occ2", 32'(occ3), 32'd2);
      check("bc.inReady2", 32'(pif3.in_ready), 32'd1);
      @(negedge clk);
      #1;
      check("bc.occHeld", 32'(occ3), 32'd2);
      check("bc.dataHeld", 32'(pif3.out_data), 32'h05);
      pif3.out_ready = 1'b1;
      @(negedge clk);
      #1;
      check("bc.outData6", 32'(pif3.out_data), 32'h06);
      check("bc.occAfter", 32'(occ3), 32'd1);
      @(negedge clk);
      #1;
      check("bc.drainValid", 32'(pif3.out_valid), 32'd0);
      check("bc.drainData", 32'(pif3.out_data), CLR ? 32'h00 : 32'h06);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/elastic_pipe_reg.md
# elastic_pipe_reg

Parametrised, enable-gated pipeline register chain with per-stage valid bits, ready/valid handshaking, bubble collapsing and synchronous flush. It generalises the single-bit enabled flip-flop into a WIDTH-bit, DEPTH-stage elastic buffer. It sits between out-of-order pipeline stages (e.g. rename→dispatch, issue→execute), where downstream stalls and mispredict flushes must be absorbed without losing or duplicating entries.

## Interface
- WIDTH, 32, payload width in bits (≥1)
- DEPTH, 2, number of register stages (≥1)
- RESET_VAL, '0, WIDTH-bit value loaded into data registers on clear (only with the macro, see Configuration)

- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low; one clock, reset is asynchronous and active-low
- flush  input  1  synchronous kill of all stored entries
- in_valid  input  1  upstream offers in_data
- in_ready  output  1  block accepts in_data this cycle
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  stage DEPTH-1 holds a valid entry
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  WIDTH  payload of stage DEPTH-1
- occupancy  output  $clog2(DEPTH+1)  number of valid stages

## Operation
- Stages s[0]..s[DEPTH-1], each {v, data}; s[0] is the input side, s[DEPTH-1] drives out_valid/out_data.
- Advance term: adv[DEPTH-1] = v[DEPTH-1] & out_ready; adv[k] = v[k] & (~v[k+1] | adv[k+1]).
- in_ready = ~flush & (~v[0] | adv[0]); accept = in_valid & in_ready.
- Per stage, next state: if s[k-1] advances, s[k] ← s[k-1] (v=1). Otherwise, if s[k] advances, v[k] ← 0. Otherwise hold (data register enable deasserted). s[0] loads in_data on accept.
- Data registers are written only when loading. A held stage never changes its data.
- Bubble collapse: an entry moves forward whenever the next stage is empty or emptying, so no stall is required when a gap exists.
- flush: all v ← 0 at the next edge. It has priority over accept and advance. out_valid is not masked during the flush cycle, so a downstream handshake in that cycle completes normally. in_ready=0 during flush.
- occupancy = popcount(v), registered value (reflects current state, not next).
- Ordering is strictly FIFO. There is no duplication and no loss, except entries removed by flush.

## Timing
- Reset (reset=0, asynchronous assertion): all v=0, out_valid=0, in_ready=1 (if flush=0), occupancy=0. Deassertion is synchronous to clk via the system reset synchroniser.
- Latency: an entry accepted at edge N is visible on out_valid at edge N+DEPTH-1 when the stages ahead are empty. With DEPTH=1, out_valid is asserted in the cycle after accept.
- Throughput: 1 entry/cycle sustained when out_ready=1. Full (occupancy=DEPTH) with out_ready=1 still accepts, through a combinational ready chain from out_ready to in_ready.
- Full and out_ready=0: in_ready=0, all data held.
- Empty: out_valid=0, out_data holds its last value (or RESET_VAL, see Configuration).
- Reset mid-operation: all entries discarded immediately, regardless of the handshake state.

## Configuration
- ELASTIC_PIPE_REG_DATA_CLEAR_EN defined: data registers are asynchronously reset to RESET_VAL. A stage's data is set to RESET_VAL whenever its v falls (advance without refill, or flush). out_data = RESET_VAL whenever out_valid=0.
- Not defined: data registers have no reset and are never cleared. out_data is don't-care while out_valid=0; after reset it is undefined until the first entry arrives. Lower area.

## Test plan
- Reset then stream: DEPTH=2, reset low 2 cycles, then feed 0x11,0x22,0x33 back-to-back with out_ready=1 → out_data 0x11,0x22,0x33 on consecutive cycles, first appearing 1 cycle after the first accept; occupancy never exceeds 2.
- Backpressure: out_ready=0, feed 0xA0,0xA1,0xA2 → first two accepted, in_ready=0 on the third, occupancy=2. Raise out_ready → 0xA0,0xA1 emitted, then 0xA2 accepted.
- Bubble collapse: DEPTH=3, load 0x5 into s[2] only with out_ready=0, then push 0x6 → 0x6 reaches s[1] within 2 cycles with no stall; occupancy=2.
- Flush with simultaneous handshake: occupancy=2, out_ready=1, in_valid=1, flush=1 for one cycle → the head entry transfers, in_ready=0, and occupancy=0 next cycle.
- Async reset mid-stream: drop reset between clock edges while occupancy=2 → out_valid=0 and occupancy=0 immediately. With the macro, out_data=RESET_VAL.
- Macro off vs on: after an entry drains, check out_data holds the stale value (off) vs RESET_VAL (on).
